// File: rtl/w21_col_mac_seq_if.sv
// w21_col_mac_seq_if: bundles the start/done handshake, the ROM/activation read port and the
// column result of one column MAC sequencer.
//   start    : begin a column pass (sampled only while idle)
//   busy     : pass in progress (RUN or DRAIN)
//   adrs_clm : row address to the weight ROM and the activation buffer
//   w_in     : signed weight for adrs_clm, same cycle
//   x_in     : signed activation for adrs_clm, same cycle
//   x_vld    : x_in valid this cycle (low = activation source stalled)
//   y        : signed column sum, held until the next accepted start
//   done     : one-cycle pulse, y valid
// Modports: slave = sequencer side, master = layer controller / memory side.
interface w21_col_mac_seq_if #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned W_W    = 21,
   parameter int unsigned X_W    = 16,
   parameter int unsigned ACC_W  = 48
);
   logic              start;
   logic              busy;
   logic [ADDR_W-1:0] adrs_clm;
   logic [W_W-1:0]    w_in;
   logic [X_W-1:0]    x_in;
   logic              x_vld;
   logic [ACC_W-1:0]  y;
   logic              done;

   modport slave (
      input  start,
      input  w_in,
      input  x_in,
      input  x_vld,
      output busy,
      output adrs_clm,
      output y,
      output done
   );

   modport master (
      output start,
      output w_in,
      output x_in,
      output x_vld,
      input  busy,
      input  adrs_clm,
      input  y,
      input  done
   );
endinterface

// File: rtl/w21_col_mac_seq.sv
// w21_col_mac_seq: walks one weight-ROM column (rows 0..N_ROWS-1), multiplies each signed
// weight by its signed activation and accumulates a single signed column sum.
// Pipeline: address/read -> product register (p_q, pv_q) -> accumulator (acc_q).
// A pass is IDLE -> RUN (one row per cycle with x_vld=1) -> DRAIN (2 cycles) -> DONE (1 cycle).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : w21_col_mac_seq_if.slave (start, busy, adrs_clm, w_in, x_in, x_vld, y, done)
// Optional build macro W21_COL_MAC_RELU_EN: when defined, negative column sums are clamped to
// zero at DONE (fused ReLU). Pipeline and timing are the same in both builds.
module w21_col_mac_seq #(
   parameter int unsigned N_ROWS = 300,
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned W_W    = 21,
   parameter int unsigned X_W    = 16,
   parameter int unsigned ACC_W  = 48
) (
   input logic                  clk,
   input logic                  rst,
   w21_col_mac_seq_if.slave     bus
);

   localparam int unsigned PROD_W = W_W + X_W;
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_ROWS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StDrain1,
      StDrain2,
      StDone
   } state_e;

   state_e                    state_q, state_d;
   logic [ADDR_W-1:0]         adrs_q, adrs_d;
   logic signed [PROD_W-1:0]  p_q, p_d;
   logic                      pv_q, pv_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]          y_q, y_d;

   logic signed [PROD_W-1:0]  w_ext, x_ext, prod;
   logic signed [ACC_W-1:0]   p_ext;
   logic [ACC_W-1:0]          result;

   // Both operands are widened to the full product width before the multiply so the
   // truncated product is the exact signed result.
   always_comb begin
      w_ext = {{X_W{bus.w_in[W_W-1]}}, bus.w_in};
      x_ext = {{W_W{bus.x_in[X_W-1]}}, bus.x_in};
      prod  = w_ext * x_ext;
      p_ext = {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
   end

   // Column result as published at DONE.
   always_comb begin
`ifdef W21_COL_MAC_RELU_EN
      result = acc_q[ACC_W-1] ? '0 : acc_q;
`else
      result = acc_q;
`endif
   end

   always_comb begin
      state_d = state_q;
      adrs_d  = adrs_q;
      p_d     = p_q;
      pv_d    = 1'b0;
      acc_d   = acc_q;
      y_d     = y_q;

      // Accumulate stage runs independently of the state; it empties during DRAIN.
      if (pv_q) begin
         acc_d = acc_q + p_ext;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StRun;
               adrs_d  = '0;
               acc_d   = '0;
            end
         end
         StRun: begin
            if (bus.x_vld) begin
               p_d  = prod;
               pv_d = 1'b1;
               if (adrs_q == LastAddr) begin
                  adrs_d  = '0;
                  state_d = StDrain1;
               end else begin
                  adrs_d = adrs_q + ADDR_W'(1);
               end
            end
         end
         StDrain1: begin
            state_d = StDrain2;
         end
         StDrain2: begin
            // Last product was accumulated on the previous edge, so acc_q is final here.
            y_d     = result;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         adrs_q  <= '0;
         p_q     <= '0;
         pv_q    <= 1'b0;
         acc_q   <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         adrs_q  <= adrs_d;
         p_q     <= p_d;
         pv_q    <= pv_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      bus.busy     = (state_q == StRun) || (state_q == StDrain1) || (state_q == StDrain2);
      bus.done     = (state_q == StDone);
      bus.adrs_clm = adrs_q;
      bus.y        = y_q;
   end

endmodule
